// File: rtl/pci_bus_arbiter_if.sv
// Request/grant and bus-phase signals shared between the PCI initiators and the central arbiter.
// The master modport is the initiator side; the slave modport is the arbiter side.
interface pci_bus_arbiter_if #(
    parameter int unsigned N_MASTERS = 4
);
    localparam int unsigned OW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    logic [N_MASTERS-1:0] req_n;
    logic                 frame_n;
    logic                 irdy_n;
    logic [N_MASTERS-1:0] gnt_n;
    logic [OW-1:0]        owner;
    logic                 bus_busy;
    logic                 timeout;

    modport master (
        output req_n, frame_n, irdy_n,
        input  gnt_n, owner, bus_busy, timeout
    );

    modport slave (
        input  req_n, frame_n, irdy_n,
        output gnt_n, owner, bus_busy, timeout
    );
endinterface

// File: rtl/pci_bus_arbiter.sv
// Central round-robin PCI bus arbiter: one-cycle turnaround between owners, reclaim of
// unused grants, optional parking on a default master.
module pci_bus_arbiter #(
    parameter int unsigned N_MASTERS   = 4,
    parameter int unsigned GNT_TIMEOUT = 16,
    parameter bit          PARK_EN     = 1'b1,
    parameter int unsigned PARK_ID     = 0
) (
    input logic              clk,
    input logic              rst_n,
    pci_bus_arbiter_if.slave bus
);
    localparam int unsigned OW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int unsigned TW = $clog2(GNT_TIMEOUT) + 1;

    typedef enum logic [1:0] {StIdle, StGrant, StBusy, StTurn} state_e;

    state_e               state_q, state_d;
    logic [N_MASTERS-1:0] gnt_n_q, gnt_n_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [OW-1:0]        last_q, last_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic                 bus_busy_q, bus_busy_d;
    logic                 timeout_q, timeout_d;

    logic [OW-1:0]        winner;
    logic [OW-1:0]        idx;
    logic                 win_found;
    logic                 any_req;
    logic                 bus_idle;
    logic                 owner_req;
    logic                 others_req;
    logic                 parked;
    logic [N_MASTERS-1:0] owner_mask;

    assign any_req    = |(~bus.req_n);
    assign bus_idle   = bus.frame_n & bus.irdy_n;
    assign owner_req  = ~bus.req_n[owner_q];
    assign owner_mask = N_MASTERS'(1) << owner_q;
    assign others_req = |(~bus.req_n & ~owner_mask);
    assign parked     = (state_q == StIdle) && PARK_EN && !gnt_n_q[PARK_ID];

    // Round-robin search starting just after the most recent winner.
    always_comb begin
        winner    = '0;
        idx       = '0;
        win_found = 1'b0;
        for (int unsigned i = 1; i <= N_MASTERS; i++) begin
            idx = OW'((32'(last_q) + i) % N_MASTERS);
            if (!win_found && !bus.req_n[idx]) begin
                winner    = idx;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_n_d   = gnt_n_q;
        owner_d   = owner_q;
        last_d    = last_q;
        tcnt_d    = tcnt_q;
        timeout_d = 1'b0;

        unique case (state_q)
            StIdle, StTurn: begin
                if (!bus.frame_n) begin
                    // Parked master starting a cycle, or a protocol error: no new grant.
                    state_d = StBusy;
                    if (parked) begin
                        owner_d = OW'(PARK_ID);
                    end else begin
                        gnt_n_d = '1;
                    end
                end else if (any_req) begin
                    state_d = StGrant;
                    gnt_n_d = ~(N_MASTERS'(1) << winner);
                    owner_d = winner;
                    last_d  = winner;
                    tcnt_d  = '0;
                end else if (PARK_EN) begin
                    state_d = StIdle;
                    gnt_n_d = ~(N_MASTERS'(1) << PARK_ID);
                    owner_d = OW'(PARK_ID);
                end else begin
                    state_d = StIdle;
                    gnt_n_d = '1;
                end
            end
            StGrant: begin
                if (!bus.frame_n) begin
                    state_d = StBusy;
                end else if (!owner_req) begin
                    state_d = StTurn;
                    gnt_n_d = '1;
                end else if (tcnt_q >= TW'(GNT_TIMEOUT - 1)) begin
                    state_d   = StTurn;
                    gnt_n_d   = '1;
                    timeout_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            StBusy: begin
                if (bus_idle) begin
                    state_d = StTurn;
                    gnt_n_d = '1;
                end else if (!owner_req && others_req) begin
                    gnt_n_d = '1;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_n_d = '1;
            end
        endcase

        bus_busy_d = (state_d == StBusy);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            gnt_n_q    <= '1;
            owner_q    <= '0;
            last_q     <= OW'(N_MASTERS - 1);
            tcnt_q     <= '0;
            bus_busy_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_n_q    <= gnt_n_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            tcnt_q     <= tcnt_d;
            bus_busy_q <= bus_busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.gnt_n    = gnt_n_q;
    assign bus.owner    = owner_q;
    assign bus.bus_busy = bus_busy_q;
    assign bus.timeout  = timeout_q;
endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed bench for pci_bus_arbiter (4 masters, timeout 16, parking on master 0).
// Inputs change at the falling edge; outputs are checked at the falling edge.
module tb_pci_bus_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    pci_bus_arbiter_if #(.N_MASTERS(4)) bus ();

    pci_bus_arbiter #(
        .N_MASTERS  (4),
        .GNT_TIMEOUT(16),
        .PARK_EN    (1'b1),
        .PARK_ID    (0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) check("onehot0", 32'($onehot0(~bus.gnt_n)), 32'd1);
    end

    // Expects master m already granted; runs a two-cycle transaction and the turnaround.
    task automatic run_tenure(input int m);
        logic [3:0] g;
        g = ~(4'b0001 << m);
        check("tenure_gnt", 32'(bus.gnt_n), 32'(g));
        check("tenure_owner", 32'(bus.owner), 32'(m));
        bus.frame_n = 1'b0;
        bus.irdy_n  = 1'b0;
        @(negedge clk);
        check("tenure_busy1", 32'(bus.bus_busy), 32'd1);
        check("tenure_hold", 32'(bus.gnt_n), 32'(g));
        bus.frame_n = 1'b1;
        @(negedge clk);
        check("tenure_busy2", 32'(bus.bus_busy), 32'd1);
        bus.irdy_n = 1'b1;
        @(negedge clk);
        check("tenure_turn", 32'(bus.gnt_n), 32'hF);
        check("tenure_idle", 32'(bus.bus_busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int order [5] = '{3, 0, 1, 2, 3};
        bus.req_n   = 4'b1111;
        bus.frame_n = 1'b1;
        bus.irdy_n  = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_gnt", 32'(bus.gnt_n), 32'hF);
        check("rst_owner", 32'(bus.owner), 32'd0);
        check("rst_busy", 32'(bus.bus_busy), 32'd0);
        check("rst_timeout", 32'(bus.timeout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single grant, transaction, turnaround
        bus.req_n = 4'b1110;
        @(negedge clk);
        check("t1_gnt", 32'(bus.gnt_n), 32'hE);
        check("t1_owner", 32'(bus.owner), 32'd0);
        check("t1_busy0", 32'(bus.bus_busy), 32'd0);
        bus.frame_n = 1'b0;
        @(negedge clk);
        check("t1_busy", 32'(bus.bus_busy), 32'd1);
        bus.frame_n = 1'b1;
        bus.req_n   = 4'b1111;
        @(negedge clk);
        check("t1_busy_clr", 32'(bus.bus_busy), 32'd0);
        check("t1_turn", 32'(bus.gnt_n), 32'hF);

        // Parking and parked-master transaction
        @(negedge clk);
        check("t4_park", 32'(bus.gnt_n), 32'hE);
        check("t4_park_owner", 32'(bus.owner), 32'd0);
        bus.frame_n = 1'b0;
        bus.irdy_n  = 1'b0;
        @(negedge clk);
        check("t4_busy", 32'(bus.bus_busy), 32'd1);
        check("t4_owner", 32'(bus.owner), 32'd0);
        check("t4_hold", 32'(bus.gnt_n), 32'hE);
        bus.req_n = 4'b1101;
        @(negedge clk);
        check("t4_release", 32'(bus.gnt_n), 32'hF);
        check("t4_still_busy", 32'(bus.bus_busy), 32'd1);
        bus.frame_n = 1'b1;
        @(negedge clk);
        check("t4_no_early", 32'(bus.gnt_n), 32'hF);
        bus.irdy_n = 1'b1;
        @(negedge clk);
        check("t4_turn", 32'(bus.gnt_n), 32'hF);
        check("t4_idle", 32'(bus.bus_busy), 32'd0);
        @(negedge clk);
        check("t4_gnt1", 32'(bus.gnt_n), 32'hD);
        check("t4_owner1", 32'(bus.owner), 32'd1);

        // Master 1 withdraws before FRAME#
        bus.req_n = 4'b1011;
        @(negedge clk);
        check("t6_turn", 32'(bus.gnt_n), 32'hF);
        check("t6_no_timeout", 32'(bus.timeout), 32'd0);
        @(negedge clk);
        check("t6_gnt2", 32'(bus.gnt_n), 32'hB);
        check("t6_owner2", 32'(bus.owner), 32'd2);
        check("t6_timeout", 32'(bus.timeout), 32'd0);

        // Unused grant revoked after 16 cycles
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            check("t3_held", 32'(bus.gnt_n), 32'hB);
            check("t3_no_pulse", 32'(bus.timeout), 32'd0);
        end
        @(negedge clk);
        check("t3_pulse", 32'(bus.timeout), 32'd1);
        check("t3_turn", 32'(bus.gnt_n), 32'hF);
        @(negedge clk);
        check("t3_pulse_end", 32'(bus.timeout), 32'd0);
        check("t3_regrant", 32'(bus.gnt_n), 32'hB);
        check("t3_owner", 32'(bus.owner), 32'd2);
        bus.req_n = 4'b1111;
        @(negedge clk);
        check("t3_drop", 32'(bus.gnt_n), 32'hF);
        @(negedge clk);
        check("t3_park", 32'(bus.gnt_n), 32'hE);

        // Asynchronous reset in the middle of a transaction
        bus.req_n = 4'b0111;
        @(negedge clk);
        check("t5_gnt3", 32'(bus.gnt_n), 32'h7);
        bus.frame_n = 1'b0;
        bus.irdy_n  = 1'b0;
        @(negedge clk);
        check("t5_busy", 32'(bus.bus_busy), 32'd1);
        check("t5_owner", 32'(bus.owner), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_gnt", 32'(bus.gnt_n), 32'hF);
        check("t5_rst_busy", 32'(bus.bus_busy), 32'd0);
        bus.frame_n = 1'b1;
        bus.irdy_n  = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_regrant", 32'(bus.gnt_n), 32'h7);
        check("t5_reowner", 32'(bus.owner), 32'd3);

        // All masters requesting: strict rotation
        bus.req_n = 4'b0000;
        foreach (order[k]) run_tenure(order[k]);
        check("t2_wrap_gnt", 32'(bus.gnt_n), 32'hE);
        check("t2_wrap_owner", 32'(bus.owner), 32'd0);

        bus.req_n = 4'b1111;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
